// File: rtl/regfile_write_queue.sv
// rtl/regfile_write_queue.sv - pending register-file write queue with read forwarding
//
// Purpose: buffers writeback results {addr, data} in a circular FIFO and
// drains them into the register file one per cycle when its write port is
// free. Readers see the youngest pending value for their address, so they
// never observe stale register-file contents while a write is still queued.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   in_valid/in_ready         producer handshake; in_addr/in_data carry the result
//   drain_en                  register-file write port available this cycle
//   RegWrite/WriteAddr/WriteData  head entry presented to the register file
//   ReadAddr1/2, RfData1/2    reader addresses and raw register-file read data
//   ReadData1/2               forwarded read data
//   count, empty              occupancy status
module regfile_write_queue #(
    parameter int MIPS_REG_ADDR_W_m1 = 4,
    parameter int MIPS_REG_DATA_W_m1 = 31,
    parameter int DEPTH              = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [MIPS_REG_ADDR_W_m1:0]   in_addr,
    input  logic [MIPS_REG_DATA_W_m1:0]   in_data,
    input  logic                          drain_en,
    output logic                          RegWrite,
    output logic [MIPS_REG_ADDR_W_m1:0]   WriteAddr,
    output logic [MIPS_REG_DATA_W_m1:0]   WriteData,
    input  logic [MIPS_REG_ADDR_W_m1:0]   ReadAddr1,
    input  logic [MIPS_REG_ADDR_W_m1:0]   ReadAddr2,
    input  logic [MIPS_REG_DATA_W_m1:0]   RfData1,
    input  logic [MIPS_REG_DATA_W_m1:0]   RfData2,
    output logic [MIPS_REG_DATA_W_m1:0]   ReadData1,
    output logic [MIPS_REG_DATA_W_m1:0]   ReadData2,
    output logic [$clog2(DEPTH):0]        count,
    output logic                          empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [MIPS_REG_ADDR_W_m1:0] addr_mem [DEPTH];
    logic [MIPS_REG_DATA_W_m1:0] data_mem [DEPTH];
    logic [PW-1:0]               head;
    logic [PW-1:0]               tail;
    logic                        push;
    logic                        pop;

    assign in_ready = (count < CW'(DEPTH));
    assign empty    = (count == '0);
    assign RegWrite = drain_en && !empty;

    assign WriteAddr = empty ? '0 : addr_mem[head];
    assign WriteData = empty ? '0 : data_mem[head];

    // Writes to register 0 complete the handshake but are dropped: $zero is
    // hard-wired, so queuing them would only waste a slot and a write cycle.
    assign push = in_valid && in_ready && (in_addr != '0);
    assign pop  = RegWrite;

    // Storage is not reset; entries are only meaningful inside [head, head+count).
    always_ff @(posedge clk) begin
        if (push) begin
            addr_mem[tail] <= in_addr;
            data_mem[tail] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                tail <= tail + PW'(1);
            end
            if (pop) begin
                head <= head + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Scan from oldest to youngest so the last match wins: the youngest
    // pending write to an address is the value the register file will end up with.
    always_comb begin
        ReadData1 = RfData1;
        ReadData2 = RfData2;
        for (int k = 0; k < DEPTH; k++) begin
            if (CW'(k) < count) begin
                if (addr_mem[head + PW'(k)] == ReadAddr1) begin
                    ReadData1 = data_mem[head + PW'(k)];
                end
                if (addr_mem[head + PW'(k)] == ReadAddr2) begin
                    ReadData2 = data_mem[head + PW'(k)];
                end
            end
        end
        if (ReadAddr1 == '0) begin
            ReadData1 = '0;
        end
        if (ReadAddr2 == '0) begin
            ReadData2 = '0;
        end
    end

endmodule

// File: tb/tb_regfile_write_queue.sv
// tb/tb_regfile_write_queue.sv - self-checking bench for regfile_write_queue
module tb_regfile_write_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_addr;
    logic [31:0] in_data;
    logic        drain_en;
    logic        RegWrite;
    logic [4:0]  WriteAddr;
    logic [31:0] WriteData;
    logic [4:0]  ReadAddr1, ReadAddr2;
    logic [31:0] RfData1, RfData2;
    logic [31:0] ReadData1, ReadData2;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    regfile_write_queue #(
        .MIPS_REG_ADDR_W_m1(4),
        .MIPS_REG_DATA_W_m1(31),
        .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .drain_en(drain_en),
        .RegWrite(RegWrite), .WriteAddr(WriteAddr), .WriteData(WriteData),
        .ReadAddr1(ReadAddr1), .ReadAddr2(ReadAddr2),
        .RfData1(RfData1), .RfData2(RfData2),
        .ReadData1(ReadData1), .ReadData2(ReadData2),
        .count(count), .empty(empty)
    );

    // Reference model: the pending writes as a plain arrival-ordered list.
    typedef struct {
        logic [4:0]  a;
        logic [31:0] d;
    } ent_t;
    ent_t mq[$];

    typedef struct {
        logic        iv;
        logic [4:0]  a;
        logic [31:0] d;
        logic        de;
        logic [4:0]  ra1, ra2;
        logic [31:0] rf1, rf2;
        logic [2:0]  e_cnt;
        logic        e_rdy;
        logic        e_rw;
        logic [4:0]  e_wa;
        logic [31:0] e_wd;
        logic [31:0] e_rd1, e_rd2;
    } vec_t;
    vec_t vt[17];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_read(input logic [4:0] ra, input logic [31:0] rf);
        logic [31:0] r;
        if (ra == 5'd0) return 32'd0;
        r = rf;
        foreach (mq[i]) if (mq[i].a == ra) r = mq[i].d;
        return r;
    endfunction

    task automatic check_model(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 32'(count), 32'(n));
        chk({tag, ".empty"}, 32'(empty), 32'(n == 0));
        chk({tag, ".in_ready"}, 32'(in_ready), 32'(n < DEPTH));
        chk({tag, ".RegWrite"}, 32'(RegWrite), 32'(drain_en && n > 0));
        chk({tag, ".WriteAddr"}, 32'(WriteAddr), (n > 0) ? 32'(mq[0].a) : 32'd0);
        chk({tag, ".WriteData"}, WriteData, (n > 0) ? mq[0].d : 32'd0);
        chk({tag, ".ReadData1"}, ReadData1, model_read(ReadAddr1, RfData1));
        chk({tag, ".ReadData2"}, ReadData2, model_read(ReadAddr2, RfData2));
    endtask

    // Advance one clock edge, updating the model from the inputs held across it.
    task automatic tick();
        bit do_pop, do_push;
        do_pop  = drain_en && (mq.size() > 0);
        do_push = in_valid && (mq.size() < DEPTH) && (in_addr != 5'd0);
        @(posedge clk);
        if (do_pop) void'(mq.pop_front());
        if (do_push) mq.push_back('{a: in_addr, d: in_data});
        #1;
    endtask

    task automatic idle_inputs();
        in_valid = 0; in_addr = 0; in_data = 0; drain_en = 0;
        ReadAddr1 = 0; ReadAddr2 = 0; RfData1 = 0; RfData2 = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        rst = 1'b0;
        #1;
    endtask

    initial begin
        //          iv a   d             de ra1 ra2 rf1          rf2          cnt rdy rw wa  wd            rd1           rd2
        vt[0]  = '{1, 5,  32'hAAAA,     0, 5,  0,  32'h0,       32'h0,       0,  1,  0, 0,  32'h0,        32'h0,        32'h0};
        vt[1]  = '{0, 0,  32'h0,        0, 5,  3,  32'h0,       32'h1234,    1,  1,  0, 5,  32'hAAAA,     32'hAAAA,     32'h1234};
        vt[2]  = '{1, 7,  32'h1,        1, 5,  7,  32'h0,       32'h9,       1,  1,  1, 5,  32'hAAAA,     32'hAAAA,     32'h9};
        vt[3]  = '{1, 7,  32'h2,        0, 5,  7,  32'h55,      32'h9,       1,  1,  0, 7,  32'h1,        32'h55,       32'h1};
        vt[4]  = '{0, 0,  32'h0,        0, 0,  7,  32'h77,      32'h9,       2,  1,  0, 7,  32'h1,        32'h0,        32'h2};
        vt[5]  = '{0, 0,  32'h0,        1, 0,  7,  32'h77,      32'h9,       2,  1,  1, 7,  32'h1,        32'h0,        32'h2};
        vt[6]  = '{0, 0,  32'h0,        1, 0,  7,  32'h77,      32'h9,       1,  1,  1, 7,  32'h2,        32'h0,        32'h2};
        vt[7]  = '{0, 0,  32'h0,        1, 0,  7,  32'h77,      32'h9,       0,  1,  0, 0,  32'h0,        32'h0,        32'h9};
        vt[8]  = '{1, 0,  32'hFFFF,     0, 0,  0,  32'h5,       32'h6,       0,  1,  0, 0,  32'h0,        32'h0,        32'h0};
        vt[9]  = '{0, 0,  32'h0,        1, 0,  0,  32'h5,       32'h6,       0,  1,  0, 0,  32'h0,        32'h0,        32'h0};
        vt[10] = '{1, 1,  32'h11,       0, 2,  0,  32'h100,     32'h0,       0,  1,  0, 0,  32'h0,        32'h100,      32'h0};
        vt[11] = '{1, 2,  32'h22,       0, 2,  0,  32'h100,     32'h0,       1,  1,  0, 1,  32'h11,       32'h100,      32'h0};
        vt[12] = '{1, 3,  32'h33,       0, 2,  0,  32'h100,     32'h0,       2,  1,  0, 1,  32'h11,       32'h22,       32'h0};
        vt[13] = '{1, 4,  32'h44,       0, 2,  0,  32'h100,     32'h0,       3,  1,  0, 1,  32'h11,       32'h22,       32'h0};
        vt[14] = '{1, 9,  32'h99,       0, 2,  9,  32'h100,     32'h3,       4,  0,  0, 1,  32'h11,       32'h22,       32'h3};
        vt[15] = '{1, 9,  32'h99,       1, 2,  9,  32'h100,     32'h3,       4,  0,  1, 1,  32'h11,       32'h22,       32'h3};
        vt[16] = '{0, 0,  32'h0,        0, 2,  9,  32'h100,     32'h3,       3,  1,  0, 2,  32'h22,       32'h22,       32'h3};

        idle_inputs();
        rst = 1'b1;
        #13;
        // Reset state, read path straight through to the register file.
        ReadAddr1 = 5'd6; RfData1 = 32'hCAFE; ReadAddr2 = 5'd0; RfData2 = 32'hBEEF;
        #1;
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.empty", 32'(empty), 32'd1);
        chk("rst.in_ready", 32'(in_ready), 32'd1);
        drain_en = 1'b1;
        #1;
        chk("rst.RegWrite", 32'(RegWrite), 32'd0);
        chk("rst.WriteAddr", 32'(WriteAddr), 32'd0);
        chk("rst.WriteData", WriteData, 32'd0);
        chk("rst.ReadData1", ReadData1, 32'hCAFE);
        chk("rst.ReadData2", ReadData2, 32'd0);
        idle_inputs();
        do_reset();

        // Directed vectors: outputs checked before the edge, then clocked.
        for (int i = 0; i < 17; i++) begin
            in_valid = vt[i].iv; in_addr = vt[i].a; in_data = vt[i].d; drain_en = vt[i].de;
            ReadAddr1 = vt[i].ra1; ReadAddr2 = vt[i].ra2; RfData1 = vt[i].rf1; RfData2 = vt[i].rf2;
            #1;
            chk($sformatf("vec%0d.count", i), 32'(count), 32'(vt[i].e_cnt));
            chk($sformatf("vec%0d.in_ready", i), 32'(in_ready), 32'(vt[i].e_rdy));
            chk($sformatf("vec%0d.RegWrite", i), 32'(RegWrite), 32'(vt[i].e_rw));
            chk($sformatf("vec%0d.WriteAddr", i), 32'(WriteAddr), 32'(vt[i].e_wa));
            chk($sformatf("vec%0d.WriteData", i), WriteData, vt[i].e_wd);
            chk($sformatf("vec%0d.ReadData1", i), ReadData1, vt[i].e_rd1);
            chk($sformatf("vec%0d.ReadData2", i), ReadData2, vt[i].e_rd2);
            tick();
        end

        // Three entries pending (2,3,4): asynchronous reset mid-cycle.
        idle_inputs();
        drain_en = 1'b1;
        #1;
        chk("arst.pre_count", 32'(count), 32'd3);
        #2;
        rst = 1'b1;
        #1;
        chk("arst.count", 32'(count), 32'd0);
        chk("arst.RegWrite", 32'(RegWrite), 32'd0);
        chk("arst.empty", 32'(empty), 32'd1);
        mq.delete();
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("arst.nowrite%0d", i), 32'(RegWrite), 32'd0);
            tick();
        end

        // Steady stream: one in, one out per cycle, pointers wrap twice.
        do_reset();
        for (int i = 1; i <= 10; i++) begin
            in_valid = 1'b1; in_addr = 5'(i); in_data = 32'(i * 16'h101); drain_en = 1'b1;
            #1;
            chk($sformatf("stream%0d.count", i), 32'(count), (i == 1) ? 32'd0 : 32'd1);
            chk($sformatf("stream%0d.WriteAddr", i), 32'(WriteAddr), (i == 1) ? 32'd0 : 32'(i - 1));
            chk($sformatf("stream%0d.RegWrite", i), 32'(RegWrite), (i == 1) ? 32'd0 : 32'd1);
            tick();
        end
        idle_inputs();
        drain_en = 1'b1;
        #1;
        chk("stream.last_addr", 32'(WriteAddr), 32'd10);
        chk("stream.last_data", WriteData, 32'(10 * 16'h101));
        tick();
        chk("stream.empty", 32'(empty), 32'd1);

        // Randomized traffic against the list model.
        do_reset();
        for (int i = 0; i < 400; i++) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_addr   = 5'($urandom_range(0, 7));
            in_data   = $urandom;
            drain_en  = ($urandom_range(0, 2) == 0);
            ReadAddr1 = 5'($urandom_range(0, 7));
            ReadAddr2 = 5'($urandom_range(0, 7));
            RfData1   = $urandom;
            RfData2   = $urandom;
            #1;
            check_model($sformatf("rnd%0d", i));
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/regfile_write_queue.md
REGFILE_WRITE_QUEUE -- requirements
Module: regfile_write_queue

Interface
REQ-001 SHALL have parameter MIPS_REG_ADDR_W_m1, default 4, register address width minus 1.
REQ-002 SHALL have parameter MIPS_REG_DATA_W_m1, default 31, register data width minus 1.
REQ-003 SHALL have parameter DEPTH, default 4, number of pending-write entries (power of 2, at least 2).
REQ-004 SHALL have port clk, input, 1, single clock; all state changes on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset; asynchronous, active-high.
REQ-006 SHALL have port in_valid, input, 1, producer offers a writeback result.
REQ-007 SHALL have port in_ready, output, 1, queue can accept this cycle.
REQ-008 SHALL have port in_addr, input, MIPS_REG_ADDR_W_m1+1, destination register.
REQ-009 SHALL have port in_data, input, MIPS_REG_DATA_W_m1+1, result value.
REQ-010 SHALL have port drain_en, input, 1, register-file write port available this cycle.
REQ-011 SHALL have port RegWrite, output, 1, write strobe to the register file.
REQ-012 SHALL have ports WriteAddr and WriteData, outputs, address and data widths, head entry presented to the register file.
REQ-013 SHALL have ports ReadAddr1 and ReadAddr2, inputs, address width, reader addresses (also driven to the register file).
REQ-014 SHALL have ports RfData1 and RfData2, inputs, data width, raw register-file read data.
REQ-015 SHALL have ports ReadData1 and ReadData2, outputs, data width, forwarded read data.
REQ-016 SHALL have ports count (clog2(DEPTH)+1 bits) and empty (1 bit), outputs, occupancy status.

Function
REQ-017 SHALL implement a circular FIFO of DEPTH {addr, data} entries with head/tail pointers that wrap modulo DEPTH.
REQ-018 SHALL drive in_ready = (count < DEPTH) combinationally; a full queue SHALL NOT use same-cycle drain to accept.
REQ-019 SHALL accept on rising edge when in_valid && in_ready; in_addr == 0 SHALL be accepted (handshake completes) but SHALL NOT be enqueued.
REQ-020 SHALL drive RegWrite = drain_en && !empty combinationally; WriteAddr/WriteData SHALL equal the head entry, or 0 when empty.
REQ-021 SHALL pop the head on the rising edge where RegWrite is 1, the same edge the register file commits it.
REQ-022 SHALL leave count unchanged on simultaneous enqueue and pop; SHALL increment it on enqueue only and decrement it on pop only.
REQ-023 SHALL keep entries in arrival order; multiple pending writes to the same address SHALL all drain in order.
REQ-024 SHALL compute ReadDataN combinationally: 0 if ReadAddrN == 0; otherwise the data of the youngest valid entry (head included) whose addr == ReadAddrN; otherwise RfDataN.
REQ-025 SHALL NOT forward the in_* value being offered in the same cycle (not yet enqueued).
REQ-026 SHALL drive empty = (count == 0).
REQ-027 SHALL have one-cycle latency from accept to the entry becoming visible to forwarding and to the RegWrite head.
REQ-028 SHALL keep entry storage unchanged when in_valid is asserted while full (no accept).

Reset
REQ-029 SHALL, while rst is high and asynchronously, clear head, tail and count; in_ready=1, empty=1, RegWrite=0, WriteAddr=0, WriteData=0.
REQ-030 SHALL discard pending entries on reset mid-operation, with no register-file write issued for them.
REQ-031 SHALL have ReadDataN = RfDataN (or 0 for address 0) immediately after reset.

Verification
REQ-032 SHALL pass: reset, drain_en=0, enqueue (5,0xAAAA) -> next cycle count=1, ReadAddr1=5 gives ReadData1=0xAAAA while RfData1=0.
REQ-033 SHALL pass: enqueue (7,1),(7,2) with drain_en=0, ReadAddr2=7 -> ReadData2=2; drain_en=1 -> RegWrite writes 7<-1 then 7<-2 on consecutive edges, after which empty=1.
REQ-034 SHALL pass: fill 4 entries with drain_en=0 -> in_ready=0, count=4, a fifth in_valid is not accepted; drain_en=1 for one edge -> count=3 and in_ready=1.
REQ-035 SHALL pass: steady stream with in_valid=1 and drain_en=1 for 10 cycles, addresses 1..10 -> count stays 1 and writes emerge in order with pointers wrapping.
REQ-036 SHALL pass: enqueue (0,0xFFFF) -> handshake completes, count stays 0, RegWrite stays 0; ReadAddr1=0 gives ReadData1=0.
REQ-037 SHALL pass: 3 entries pending, assert rst asynchronously mid-cycle -> count=0, RegWrite=0 at once, no write to those addresses is seen afterward.
